// File: rtl/sound_mux_arb.sv
// ---------------------------------------------------------------------------
// sound_mux_arb
//
// Arbitrates N_CH one-bit tone sources onto a single speaker pin. The game
// FSM fires one-cycle play requests; the highest requested channel plays for
// DURATION ticks. A higher-priority request preempts the current sound.
// Source switches wait for the old tone to go low, or for DRAIN_MAX cycles,
// so the speaker never shows a clipped high pulse. Mute blanks the output
// without touching timing.
//
// Ports:
//   clk       - system clock
//   rst       - synchronous reset, active low
//   req       - per-channel play request pulses (bit index = channel)
//   src       - per-channel tone square waves
//   mute      - forces the speaker low
//   speaker   - registered speaker drive
//   busy      - high while a sound is playing or draining
//   active_ch - channel currently selected, 0 when idle
// ---------------------------------------------------------------------------
module sound_mux_arb #(
    parameter int N_CH      = 4,
    parameter int CH_W      = 2,
    parameter int TICK_DIV  = 50000,
    parameter int DUR_W     = 12,
    parameter int DURATION  = 1500,
    parameter int DRAIN_MAX = 65535
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [N_CH-1:0] req,
    input  logic [N_CH-1:0] src,
    input  logic            mute,
    output logic            speaker,
    output logic            busy,
    output logic [CH_W-1:0] active_ch
);

    localparam int PRE_W = $clog2(TICK_DIV);
    localparam int DRN_W = $clog2(DRAIN_MAX + 1);

    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(TICK_DIV - 1);
    localparam logic [DUR_W-1:0] DUR_LOAD = DUR_W'(DURATION);
    localparam logic [DUR_W-1:0] DUR_ONE  = DUR_W'(1);
    localparam logic [DRN_W-1:0] DRN_LAST = DRN_W'(DRAIN_MAX - 1);

    typedef enum logic [1:0] {
        IDLE,
        PLAY,
        DRAIN
    } state_t;

    state_t            r_state;
    logic [CH_W-1:0]   r_curCh;
    logic [CH_W-1:0]   r_pendCh;
    logic              r_pendValid;
    logic [DUR_W-1:0]  r_dur;
    logic [PRE_W-1:0]  r_presc;
    logic [DRN_W-1:0]  r_drainCnt;
    logic              r_speaker;

    state_t            w_state;
    logic [CH_W-1:0]   w_curCh;
    logic [CH_W-1:0]   w_pendCh;
    logic              w_pendValid;
    logic [DUR_W-1:0]  w_dur;
    logic [PRE_W-1:0]  w_presc;
    logic [DRN_W-1:0]  w_drainCnt;
    logic              w_speaker;

    logic              w_reqAny;
    logic [CH_W-1:0]   w_reqHi;
    logic              w_srcBit;
    logic              w_tickWrap;
    logic [CH_W-1:0]   w_drainRef;

    // Priority encoder: the last set bit seen while scanning upward is the
    // highest-index (highest-priority) request.
    always_comb begin
        w_reqAny = |req;
        w_reqHi  = '0;
        for (int i = 0; i < N_CH; i++) begin
            if (req[i]) begin
                w_reqHi = CH_W'(i);
            end
        end
    end

    // Pending is only ever set above the current channel, so when it is
    // valid it alone is the bar a new drain-time request has to clear.
    assign w_srcBit   = src[r_curCh];
    assign w_tickWrap = (r_presc == PRE_LAST);
    assign w_drainRef = r_pendValid ? r_pendCh : r_curCh;

    // Next-state and next-output logic. Preemption is tested before
    // retrigger and expiry so it wins a coincident expiry tick; retrigger is
    // tested before expiry so an equal request on the last tick extends play.
    always_comb begin
        w_state     = r_state;
        w_curCh     = r_curCh;
        w_pendCh    = r_pendCh;
        w_pendValid = r_pendValid;
        w_dur       = r_dur;
        w_presc     = r_presc;
        w_drainCnt  = r_drainCnt;
        w_speaker   = 1'b0;

        case (r_state)
            IDLE: begin
                if (w_reqAny) begin
                    w_state     = PLAY;
                    w_curCh     = w_reqHi;
                    w_dur       = DUR_LOAD;
                    w_presc     = '0;
                    w_pendValid = 1'b0;
                end
            end

            PLAY: begin
                w_speaker = w_srcBit & ~mute;
                if (w_reqAny && (w_reqHi > r_curCh)) begin
                    w_state     = DRAIN;
                    w_pendCh    = w_reqHi;
                    w_pendValid = 1'b1;
                    w_drainCnt  = '0;
                end else if (w_reqAny && (w_reqHi == r_curCh)) begin
                    w_dur   = DUR_LOAD;
                    w_presc = '0;
                end else if (w_tickWrap) begin
                    w_presc = '0;
                    w_dur   = r_dur - DUR_ONE;
                    if (r_dur == DUR_ONE) begin
                        w_state     = DRAIN;
                        w_pendValid = 1'b0;
                        w_drainCnt  = '0;
                    end
                end else begin
                    w_presc = r_presc + 1'b1;
                end
            end

            DRAIN: begin
                if (w_reqAny && (w_reqHi > w_drainRef)) begin
                    w_pendCh    = w_reqHi;
                    w_pendValid = 1'b1;
                end
                // Leave only once the old tone is low (no clipped high
                // phase), or when the timeout forces a cut.
                if (!w_srcBit || (r_drainCnt == DRN_LAST)) begin
                    w_speaker  = 1'b0;
                    w_drainCnt = '0;
                    if (w_pendValid) begin
                        w_state     = PLAY;
                        w_curCh     = w_pendCh;
                        w_dur       = DUR_LOAD;
                        w_presc     = '0;
                        w_pendValid = 1'b0;
                    end else begin
                        w_state = IDLE;
                    end
                end else begin
                    w_speaker  = w_srcBit & ~mute;
                    w_drainCnt = r_drainCnt + 1'b1;
                end
            end

            default: begin
                w_state = IDLE;
            end
        endcase
    end

    // State register. Reset aborts any play or drain immediately.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state     <= IDLE;
            r_curCh     <= '0;
            r_pendCh    <= '0;
            r_pendValid <= 1'b0;
            r_dur       <= '0;
            r_presc     <= '0;
            r_drainCnt  <= '0;
            r_speaker   <= 1'b0;
        end else begin
            r_state     <= w_state;
            r_curCh     <= w_curCh;
            r_pendCh    <= w_pendCh;
            r_pendValid <= w_pendValid;
            r_dur       <= w_dur;
            r_presc     <= w_presc;
            r_drainCnt  <= w_drainCnt;
            r_speaker   <= w_speaker;
        end
    end

    assign speaker   = r_speaker;
    assign busy      = (r_state != IDLE);
    assign active_ch = (r_state == IDLE) ? '0 : r_curCh;

endmodule

// File: tb/tb_sound_mux_arb.sv
// ---------------------------------------------------------------------------
// tb_sound_mux_arb
//
// Directed bench for sound_mux_arb with TICK_DIV=4, DURATION=3, DRAIN_MAX=8,
// N_CH=4, so one full play lasts 12 clock cycles. Inputs change 1 time unit
// after a rising edge and outputs are checked at that same point, so each
// check sees the registers updated by the edge that just passed.
// ---------------------------------------------------------------------------
module tb_sound_mux_arb;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] req;
    logic [3:0] src;
    logic       mute;
    logic       speaker;
    logic       busy;
    logic [1:0] active_ch;

    int compared   = 0;
    int mismatched = 0;
    logic mv;

    sound_mux_arb #(
        .N_CH      (4),
        .CH_W      (2),
        .TICK_DIV  (4),
        .DUR_W     (12),
        .DURATION  (3),
        .DRAIN_MAX (8)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .src       (src),
        .mute      (mute),
        .speaker   (speaker),
        .busy      (busy),
        .active_ch (active_ch)
    );

    always #5 clk = ~clk;

    task automatic applyStimulus(input logic r, input logic [3:0] rq,
                                 input logic [3:0] s, input logic m);
        rst  = r;
        req  = rq;
        src  = s;
        mute = m;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic eSpk,
                               input logic eBusy, input logic [1:0] eCh);
        compared++;
        assert (speaker === eSpk) else begin
            mismatched++;
            $error("[TB] FAIL %s speaker observed=%0b expected=%0b", tag, speaker, eSpk);
        end
        compared++;
        assert (busy === eBusy) else begin
            mismatched++;
            $error("[TB] FAIL %s busy observed=%0b expected=%0b", tag, busy, eBusy);
        end
        compared++;
        assert (active_ch === eCh) else begin
            mismatched++;
            $error("[TB] FAIL %s active_ch observed=%0d expected=%0d", tag, active_ch, eCh);
        end
    endtask

    // Tone pattern toggling every two cycles: 1,1,0,0,1,1,0,0,...
    // Low on play cycles 10-11 and high on 12-13, so an early or late
    // expiry shows up as a wrong busy value.
    function automatic logic pat(input int j);
        return ((((j / 2) + 1) % 2) == 1);
    endfunction

    // Runs from the first PLAY cycle of channel ch: 12 PLAY cycles, then
    // two DRAIN cycles with the tone high, then the tone goes low and the
    // block returns to IDLE.
    task automatic runFullPlay(input int ch, input string tag);
        logic [3:0] s;
        for (int j = 0; j < 15; j++) begin
            s     = '0;
            s[ch] = pat(j);
            applyStimulus(1'b1, 4'b0000, s, 1'b0);
            tick();
            checkOutput($sformatf("%s_%0d", tag, j), pat(j), (j < 14),
                        (j < 14) ? 2'(ch) : 2'd0);
        end
    endtask

    initial begin
        // Reset held with every request and source high
        applyStimulus(1'b0, 4'b1111, 4'b1111, 1'b0);
        for (int k = 0; k < 3; k++) begin
            tick();
            checkOutput($sformatf("reset_%0d", k), 1'b0, 1'b0, 2'd0);
        end
        applyStimulus(1'b1, 4'b0000, 4'b0000, 1'b0);
        tick();
        checkOutput("idleAfterReset", 1'b0, 1'b0, 2'd0);

        // Single play on channel 1
        applyStimulus(1'b1, 4'b0010, 4'b0000, 1'b0);
        tick();
        checkOutput("singleStart", 1'b0, 1'b1, 2'd1);
        runFullPlay(1, "single");

        // Preemption of channel 1 by channel 3, with the ch1 tone still high
        applyStimulus(1'b1, 4'b0010, 4'b0000, 1'b0);
        tick();
        checkOutput("preStart", 1'b0, 1'b1, 2'd1);
        applyStimulus(1'b1, 4'b0000, 4'b0010, 1'b0);
        tick();
        checkOutput("preJ0", 1'b1, 1'b1, 2'd1);
        applyStimulus(1'b1, 4'b1000, 4'b0010, 1'b0);
        tick();
        checkOutput("preReq", 1'b1, 1'b1, 2'd1);
        applyStimulus(1'b1, 4'b0000, 4'b0010, 1'b0);
        tick();
        checkOutput("preDrain0", 1'b1, 1'b1, 2'd1);
        tick();
        checkOutput("preDrain1", 1'b1, 1'b1, 2'd1);
        applyStimulus(1'b1, 4'b0000, 4'b0000, 1'b0);
        tick();
        checkOutput("preSwitch", 1'b0, 1'b1, 2'd3);
        runFullPlay(3, "preCh3");

        // Lower request ignored, equal request at dur=1 retriggers
        applyStimulus(1'b1, 4'b0100, 4'b0000, 1'b0);
        tick();
        checkOutput("lowStart", 1'b0, 1'b1, 2'd2);
        for (int j = 0; j < 10; j++) begin
            applyStimulus(1'b1, (j == 0) ? 4'b0001 : ((j == 9) ? 4'b0100 : 4'b0000),
                          4'b0100, 1'b0);
            tick();
            checkOutput($sformatf("lowPlay_%0d", j), 1'b1, 1'b1, 2'd2);
        end
        for (int r = 0; r < 12; r++) begin
            applyStimulus(1'b1, 4'b0000, 4'b0100, 1'b0);
            tick();
            checkOutput($sformatf("retrig_%0d", r), 1'b1, 1'b1, 2'd2);
        end
        applyStimulus(1'b1, 4'b0000, 4'b0000, 1'b0);
        tick();
        checkOutput("retrigEnd", 1'b0, 1'b0, 2'd0);

        // Simultaneous requests, then expiry coinciding with a higher request
        applyStimulus(1'b1, 4'b0110, 4'b0000, 1'b0);
        tick();
        checkOutput("simStart", 1'b0, 1'b1, 2'd2);
        for (int j = 0; j < 12; j++) begin
            applyStimulus(1'b1, (j == 11) ? 4'b1000 : 4'b0000, 4'b0000, 1'b0);
            tick();
            checkOutput($sformatf("simPlay_%0d", j), 1'b0, 1'b1, 2'd2);
        end
        applyStimulus(1'b1, 4'b0000, 4'b0000, 1'b0);
        tick();
        checkOutput("simSwitch", 1'b0, 1'b1, 2'd3);
        runFullPlay(3, "simCh3");

        // Drain timeout with the tone stuck high
        applyStimulus(1'b1, 4'b0001, 4'b0001, 1'b0);
        tick();
        checkOutput("toStart", 1'b0, 1'b1, 2'd0);
        applyStimulus(1'b1, 4'b0000, 4'b0001, 1'b0);
        for (int j = 0; j < 12; j++) begin
            tick();
            checkOutput($sformatf("toPlay_%0d", j), 1'b1, 1'b1, 2'd0);
        end
        for (int d = 0; d < 8; d++) begin
            tick();
            checkOutput($sformatf("toDrain_%0d", d), (d < 7), (d < 7), 2'd0);
        end

        // Mute blanks the speaker without moving the expiry cycle
        applyStimulus(1'b1, 4'b0010, 4'b0010, 1'b1);
        tick();
        checkOutput("muteStart", 1'b0, 1'b1, 2'd1);
        for (int j = 0; j < 12; j++) begin
            mv = !((j >= 6) && (j <= 8));
            applyStimulus(1'b1, 4'b0000, 4'b0010, mv);
            tick();
            checkOutput($sformatf("mutePlay_%0d", j), !mv, 1'b1, 2'd1);
        end
        applyStimulus(1'b1, 4'b0000, 4'b0000, 1'b1);
        tick();
        checkOutput("muteEnd", 1'b0, 1'b0, 2'd0);

        // Reset asserted mid-play aborts at once
        applyStimulus(1'b1, 4'b1000, 4'b1000, 1'b0);
        tick();
        checkOutput("abortStart", 1'b0, 1'b1, 2'd3);
        applyStimulus(1'b1, 4'b0000, 4'b1000, 1'b0);
        tick();
        checkOutput("abortPlay", 1'b1, 1'b1, 2'd3);
        applyStimulus(1'b0, 4'b0000, 4'b1000, 1'b0);
        tick();
        checkOutput("abortReset", 1'b0, 1'b0, 2'd0);
        applyStimulus(1'b1, 4'b0000, 4'b1000, 1'b0);
        tick();
        checkOutput("abortIdle", 1'b0, 1'b0, 2'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
